reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- Architectural register file directly upstream of the 32-bit ALU datapath built from alu_1b slices.
- Supplies the ALU's a and b operands through two combinational read ports.
- Accepts one write per clock from the writeback path (ALU result or memory data).
- Register 0 is hardwired to zero, per the MIPS-style single-cycle CPU this block serves.

Parameters:
- DATA_W, 32, width of each register and of the read/write data ports.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W entries.
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port; when 0 the read returns the stored value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- read_reg1  input  ADDR_W  address for read port 1 (drives the ALU a operand).
- read_reg2  input  ADDR_W  address for read port 2 (drives the ALU b operand or store data).
- write_reg  input  ADDR_W  destination address.
- write_data  input  DATA_W  data to write.
- reg_write  input  1  write enable.
- read_data1  output  DATA_W  contents of read_reg1.
- read_data2  output  DATA_W  contents of read_reg2.

Behaviour:
- Reset:
  - rst_n low clears entries 1..2**ADDR_W-1 to 0 immediately, without waiting for a clock edge.
  - While rst_n is low, read_data1 and read_data2 read 0 for every address.
  - Writes presented while rst_n is low are discarded.
  - Reset asserted mid-write wins: the entry ends at 0.
- Write:
  - On a rising clk edge with rst_n high, reg_write=1 and write_reg!=0, entry[write_reg] <= write_data.
  - reg_write=0 leaves all entries unchanged.
  - A write to address 0 is silently dropped.
- Read:
  - Purely combinational, zero-cycle latency.
  - read_dataN = entry[read_regN].
  - Address 0 always returns 0, regardless of BYPASS or a pending write.
- Bypass (BYPASS=1):
  - Applies when reg_write=1, write_reg!=0 and read_regN==write_reg.
  - read_dataN = write_data in the same cycle, so a single-cycle CPU can read its own writeback with no hazard.
  - Both ports may bypass simultaneously, including when both read the same address.
- No bypass (BYPASS=0): the same conditions return the pre-edge stored value; the new value appears after the rising edge.
- Read/write at different addresses in the same cycle are independent; no port blocks another.
- There is no write-after-write hazard: one write port, one write per cycle.
- Width rules:
  - write_data is stored unmodified.
  - Addresses are interpreted as unsigned.
  - All 2**ADDR_W addresses are valid, so there is no out-of-range case.

Decomposition:
- Shared package (cpu_defs) holds:
  - DATA_W=32, ADDR_W=5, REG_ZERO=5'd0.
  - NUM_REGS=2**ADDR_W.
  - the reg_addr_t and word_t typedefs, also used by the control unit and the ALU.
- Sub-module reg_word:
  - one DATA_W-bit register with load enable and asynchronous active-low clear.
  - instantiated NUM_REGS-1 times (entries 1..31); entry 0 is a constant.
- The top level holds:
  - the write-address decoder producing per-entry enables;
  - two NUM_REGS:1 read multiplexers;
  - the per-port bypass compare/select.

Test Plan:
- Reset: assert rst_n=0 after writing 0xDEADBEEF to r5; read r5 while still in reset -> 0x00000000, asynchronously, with no clock edge.
- Basic write/read: write r7=0x12345678 and r31=0xFFFFFFFF on consecutive cycles, then read r7 on port 1 and r31 on port 2 -> 0x12345678 and 0xFFFFFFFF.
- Zero register: write r0=0xAAAAAAAA with reg_write=1, then read r0 on both ports -> 0x00000000, including in the write cycle itself with BYPASS=1.
- Bypass: with r3=0x11, same cycle reg_write=1, write_reg=3, write_data=0x22, read_reg1=read_reg2=3 -> 0x22 on both ports when BYPASS=1; 0x11 when BYPASS=0, then 0x22 after the edge.
- Enable gating: write_reg=9, write_data=0x55, reg_write=0 for 3 cycles -> r9 stays 0; one cycle with reg_write=1 -> r9=0x55 after that edge.
- Exhaustive sweep: write each rN=N*0x01010101 for N=1..31, read back all 32 pairs across both ports -> expected patterns; r0 reads 0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU datapath definitions: word/register-address types and register-file geometry,
// used by the register file, control unit and ALU.
package cpu_defs;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_file_2r1w_reg_word.sv
// One architectural register: load-enabled, cleared immediately by the asynchronous reset.
module reg_word
    import cpu_defs::*;
#(
    parameter int W = cpu_defs::DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write architectural register file with r0 tied to zero and optional
// same-cycle write-to-read forwarding so the writeback result is visible immediately.
module reg_file_2r1w
    import cpu_defs::*;
#(
    parameter int DATA_W = cpu_defs::DATA_W,
    parameter int ADDR_W = cpu_defs::ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] w_entries [0:DEPTH-1];
    logic              w_we      [1:DEPTH-1];
    logic              w_wr_live;
    logic              w_byp1;
    logic              w_byp2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // A write to r0 never takes effect, so it can never be forwarded either.
    assign w_wr_live = reg_write && (write_reg != ADDR_W'(REG_ZERO));

    assign w_entries[0] = '0;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_word
            assign w_we[gi] = w_wr_live && (write_reg == ADDR_W'(gi));

            reg_word #(
                .W (DATA_W)
            ) u_word (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_load (w_we[gi]),
                .i_d    (write_data),
                .o_q    (w_entries[gi])
            );
        end
    endgenerate

    assign w_rd1 = w_entries[read_reg1];
    assign w_rd2 = w_entries[read_reg2];

    assign w_byp1 = BYPASS && w_wr_live && (read_reg1 == write_reg);
    assign w_byp2 = BYPASS && w_wr_live && (read_reg2 == write_reg);

    // Outputs are forced to zero during reset so a pending write is not forwarded.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (rst_n) begin
            read_data1 = w_byp1 ? write_data : w_rd1;
            read_data2 = w_byp2 ? write_data : w_rd2;
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: BYPASS=1 and BYPASS=0 instances share stimulus; expected reads
// are queued by the stimulus process and checked by an independent monitor at each negedge.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic        reg_write = 1'b0;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       nm;
        logic [31:0] e1b;
        logic [31:0] e2b;
        logic [31:0] e1n;
        logic [31:0] e2n;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [31:0] K = 32'h0101_0101;

    always #5 clk = ~clk;

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (rd1_b),
        .read_data2 (rd2_b)
    );

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (rd1_n),
        .read_data2 (rd2_n)
    );

    task automatic cmp(input string nm, input string port, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %08h, expected %08h", nm, port, act, exp);
        end
    endtask

    // Monitor: reads are combinational, so each queued expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp(e.nm, "byp.rd1", rd1_b, e.e1b);
            cmp(e.nm, "byp.rd2", rd2_b, e.e2b);
            cmp(e.nm, "nob.rd1", rd1_n, e.e1n);
            cmp(e.nm, "nob.rd2", rd2_n, e.e2n);
            $display("txn %-12s rr1=%0d rr2=%0d we=%0b wr=%0d wd=%08h | b:%08h/%08h n:%08h/%08h",
                     e.nm, read_reg1, read_reg2, reg_write, write_reg, write_data,
                     rd1_b, rd2_b, rd1_n, rd2_n);
        end
    end

    task automatic drive(input logic [4:0] rr1, input logic [4:0] rr2, input logic [4:0] wr,
                         input logic [31:0] wd, input logic we);
        read_reg1  = rr1;
        read_reg2  = rr2;
        write_reg  = wr;
        write_data = wd;
        reg_write  = we;
    endtask

    task automatic push(input string nm, input logic [31:0] e1b, input logic [31:0] e2b,
                        input logic [31:0] e1n, input logic [31:0] e2n);
        exp_t e;
        e.nm  = nm;
        e.e1b = e1b;
        e.e2b = e2b;
        e.e1n = e1n;
        e.e2n = e2n;
        sb_q.push_back(e);
    endtask

    // One cycle: drive just after the rising edge, queue what the reads must show this cycle.
    task automatic step(input string nm, input logic [4:0] rr1, input logic [4:0] rr2,
                        input logic [4:0] wr, input logic [31:0] wd, input logic we,
                        input logic [31:0] e1b, input logic [31:0] e2b,
                        input logic [31:0] e1n, input logic [31:0] e2n);
        @(posedge clk);
        #1;
        drive(rr1, rr2, wr, wd, we);
        push(nm, e1b, e2b, e1n, e2n);
    endtask

    initial begin
        step("rst_state", 5, 7, 5, 32'h1111_1111, 1'b1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(5, 7, 0, 0, 1'b0);
        rst_n = 1'b1;

        // Reset: write r5, confirm, then reset asynchronously with a write still pending.
        step("w5", 5, 0, 5, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 0, 0, 0);
        step("r5", 5, 5, 0, 0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        drive(5, 5, 5, 32'hDEAD_BEEF, 1'b1);
        #2;
        rst_n = 1'b0;
        push("rst_async", 0, 0, 0, 0);
        step("rst_wr_drop", 5, 5, 5, 32'h1234_5678, 1'b1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(5, 5, 0, 0, 1'b0);
        rst_n = 1'b1;
        step("r5_cleared", 5, 5, 0, 0, 1'b0, 0, 0, 0, 0);

        // Basic write/read on consecutive cycles.
        step("w7", 7, 31, 7, 32'h1234_5678, 1'b1, 32'h1234_5678, 0, 0, 0);
        step("w31", 7, 31, 31, 32'hFFFF_FFFF, 1'b1,
             32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 0);
        step("rd7_31", 7, 31, 0, 0, 1'b0,
             32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF);

        // Zero register ignores writes, also in the write cycle.
        step("w0", 0, 0, 0, 32'hAAAA_AAAA, 1'b1, 0, 0, 0, 0);
        step("r0", 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);

        // Bypass on both ports at the same address.
        step("w3", 0, 0, 3, 32'h11, 1'b1, 0, 0, 0, 0);
        step("byp3", 3, 3, 3, 32'h22, 1'b1, 32'h22, 32'h22, 32'h11, 32'h11);
        step("after3", 3, 3, 0, 0, 1'b0, 32'h22, 32'h22, 32'h22, 32'h22);

        // Enable gating.
        for (int i = 0; i < 3; i++)
            step("gate9", 9, 9, 9, 32'h55, 1'b0, 0, 0, 0, 0);
        step("we9", 9, 9, 9, 32'h55, 1'b1, 32'h55, 32'h55, 0, 0);
        step("r9", 9, 9, 0, 0, 1'b0, 32'h55, 32'h55, 32'h55, 32'h55);

        // Sweep: write rN = N*K, reading the previous entry on port 2.
        for (int n = 1; n < 32; n++) begin
            logic [31:0] prev;
            prev = 32'(n - 1) * K;
            step("sweep_w", 0, 5'(n - 1), 5'(n), 32'(n) * K, 1'b1, 0, prev, 0, prev);
        end
        for (int n = 0; n < 32; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = 32'(n) * K;
            b = 32'(31 - n) * K;
            step("sweep_r", 5'(n), 5'(31 - n), 0, 0, 1'b0, a, b, a, b);
        end

        // One port bypasses while the other reads an unrelated entry.
        step("byp_p2", 4, 6, 6, 32'hCAFE_F00D, 1'b1, 4 * K, 32'hCAFE_F00D, 4 * K, 6 * K);
        step("r6", 6, 4, 0, 0, 1'b0, 32'hCAFE_F00D, 4 * K, 32'hCAFE_F00D, 4 * K);

        repeat (2) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
